// File: rtl/s2p_if.sv
// rtl/s2p_if.sv - serial beat input and parallel vector output bundle for s2p
interface s2p_if #(
   parameter int DATA_WIDTH   = 12,
   parameter int NUM_ELEMENTS = 5
);
   logic                  s2p_ready_in;
   logic                  s2p_valid_in;
   logic [DATA_WIDTH-1:0] s2p_serial_in;
   logic                  s2p_ready_out;
   logic                  s2p_valid_out;
   logic [DATA_WIDTH-1:0] s2p_parallel_out [0:NUM_ELEMENTS-1];

   // master is the surrounding pipeline (beat producer and vector consumer); slave is the converter
   modport master (
      input  s2p_ready_in, s2p_valid_out, s2p_parallel_out,
      output s2p_valid_in, s2p_serial_in, s2p_ready_out
   );
   modport slave (
      input  s2p_valid_in, s2p_serial_in, s2p_ready_out,
      output s2p_ready_in, s2p_valid_out, s2p_parallel_out
   );
endinterface

// File: rtl/s2p.sv
// rtl/s2p.sv - serial-to-parallel converter with a fill buffer and an output register
module s2p #(
   parameter int DATA_WIDTH   = 12,
   parameter int NUM_ELEMENTS = 5
) (
   input  logic  clk,
   input  logic  rst,
   s2p_if.slave  bus
);
   localparam int            CW   = $clog2(NUM_ELEMENTS);
   localparam logic [CW-1:0] LAST = CW'(NUM_ELEMENTS - 1);

   typedef enum logic {FILL = 1'b0, HELD = 1'b1} state_t;
   typedef logic [DATA_WIDTH-1:0] vec_t [0:NUM_ELEMENTS-1];

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   vec_t          fill_q, fill_d;
   vec_t          out_q, out_d;
   logic          valid_q, valid_d;

   logic ready_in;
   logic out_free;
   logic accept;

   assign ready_in = (state_q == FILL);
   assign out_free = ~valid_q | bus.s2p_ready_out;
   assign accept   = ready_in & bus.s2p_valid_in;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
      out_d   = out_q;
      valid_d = valid_q & ~bus.s2p_ready_out;
      case (state_q)
         FILL: begin
            if (accept) begin
               fill_d[cnt_q] = bus.s2p_serial_in;
               if (cnt_q == LAST) begin
                  cnt_d = '0;
                  if (out_free) begin
                     // last element bypasses the fill buffer so a complete vector loads with no extra cycle
                     out_d       = fill_q;
                     out_d[LAST] = bus.s2p_serial_in;
                     valid_d     = 1'b1;
                  end else begin
                     state_d = HELD;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         HELD: begin
            if (out_free) begin
               out_d   = fill_q;
               valid_d = 1'b1;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         fill_q  <= '{default: '0};
         out_q   <= '{default: '0};
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign bus.s2p_ready_in     = ready_in;
   assign bus.s2p_valid_out    = valid_q;
   assign bus.s2p_parallel_out = out_q;
endmodule

// File: tb/tb_s2p.sv
// tb/tb_s2p.sv - directed bench for s2p with an expected-vector scoreboard
module tb_s2p;
   localparam int DW = 12;
   localparam int NE = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   s2p_if #(.DATA_WIDTH(DW), .NUM_ELEMENTS(NE)) bus ();

   s2p #(.DATA_WIDTH(DW), .NUM_ELEMENTS(NE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;
   logic [63:0]   exp_q [$];
   int            hs_cyc [$];
   logic [DW-1:0] mbuf [NE];
   int            mcnt = 0;
   logic          stall_seen = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] out_vec();
      logic [63:0] v = '0;
      for (int i = 0; i < NE; i++) v[i*DW +: DW] = bus.s2p_parallel_out[i];
      return v;
   endfunction

   function automatic logic [63:0] seq_vec(input int base);
      logic [63:0] v = '0;
      for (int i = 0; i < NE; i++) v[i*DW +: DW] = DW'(base + i);
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds the beat until accepted; the model records it and queues each completed vector.
   task automatic send_beat(input logic [DW-1:0] d);
      logic        r;
      int          n = 0;
      logic [63:0] v;
      bus.s2p_valid_in  = 1'b1;
      bus.s2p_serial_in = d;
      do begin
         r = bus.s2p_ready_in;
         if (!r) stall_seen = 1'b1;
         step();
         n++;
      end while (!r && n < 50);
      if (!r) chk("beat_accept_timeout", {63'b0, r}, 64'd1);
      mbuf[mcnt] = d;
      if (mcnt == NE - 1) begin
         v = '0;
         for (int i = 0; i < NE; i++) v[i*DW +: DW] = mbuf[i];
         exp_q.push_back(v);
         mcnt = 0;
      end else begin
         mcnt++;
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && bus.s2p_valid_out === 1'b1 && bus.s2p_ready_out === 1'b1) begin
         hs_cyc.push_back(cyc);
         if (exp_q.size() == 0) chk("unexpected_vector", 64'(exp_q.size()), 64'd1);
         else chk("vector", out_vec(), exp_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int h0;
      int gap;
      rst               = 1'b0;
      bus.s2p_valid_in  = 1'b0;
      bus.s2p_serial_in = '0;
      bus.s2p_ready_out = 1'b1;
      #12;
      chk("reset_valid", {63'b0, bus.s2p_valid_out}, 64'd0);
      chk("reset_data", out_vec(), 64'd0);
      chk("reset_ready", {63'b0, bus.s2p_ready_in}, 64'd1);
      @(negedge clk) rst = 1'b1;
      step();

      // single vector
      for (int i = 1; i <= 5; i++) send_beat(DW'(i));
      chk("single_valid", {63'b0, bus.s2p_valid_out}, 64'd1);
      chk("single_data", out_vec(), seq_vec(1));
      bus.s2p_valid_in = 1'b0;
      step();
      chk("single_valid_drop", {63'b0, bus.s2p_valid_out}, 64'd0);
      chk("single_data_kept", out_vec(), seq_vec(1));

      // streaming
      h0 = hs_cyc.size();
      stall_seen = 1'b0;
      for (int i = 0; i < 20; i++) send_beat(DW'(i));
      bus.s2p_valid_in = 1'b0;
      step();
      step();
      chk("stream_count", 64'(hs_cyc.size() - h0), 64'd4);
      if (hs_cyc.size() - h0 >= 4)
         for (int k = 1; k < 4; k++)
            chk("stream_spacing", 64'(hs_cyc[h0+k] - hs_cyc[h0+k-1]), 64'd5);
      chk("stream_no_stall", {63'b0, stall_seen}, 64'd0);

      // backpressure
      bus.s2p_ready_out = 1'b0;
      for (int i = 0; i < 10; i++) send_beat(DW'(i));
      chk("bp_ready_low", {63'b0, bus.s2p_ready_in}, 64'd0);
      chk("bp_valid", {63'b0, bus.s2p_valid_out}, 64'd1);
      chk("bp_first", out_vec(), seq_vec(0));
      bus.s2p_valid_in = 1'b0;
      repeat (3) step();
      chk("bp_hold", out_vec(), seq_vec(0));
      chk("bp_ready_still_low", {63'b0, bus.s2p_ready_in}, 64'd0);
      bus.s2p_ready_out = 1'b1;
      step();
      chk("bp_second", out_vec(), seq_vec(5));
      chk("bp_valid_no_bubble", {63'b0, bus.s2p_valid_out}, 64'd1);
      chk("bp_ready_back", {63'b0, bus.s2p_ready_in}, 64'd1);
      step();
      chk("bp_drained", {63'b0, bus.s2p_valid_out}, 64'd0);

      // gapped input
      h0 = hs_cyc.size();
      for (int i = 0; i < 15; i++) begin
         send_beat(DW'($urandom_range(0, 4095)));
         gap = $urandom_range(0, 3);
         if (gap > 0) begin
            bus.s2p_valid_in = 1'b0;
            repeat (gap) step();
         end
      end
      bus.s2p_valid_in = 1'b0;
      step();
      step();
      chk("gap_count", 64'(hs_cyc.size() - h0), 64'd3);
      chk("gap_drain", 64'(exp_q.size()), 64'd0);

      // reset mid-vector
      for (int i = 7; i <= 9; i++) send_beat(DW'(i));
      bus.s2p_valid_in = 1'b0;
      step();
      rst = 1'b0;
      #2;
      chk("rst_mid_valid", {63'b0, bus.s2p_valid_out}, 64'd0);
      chk("rst_mid_data", out_vec(), 64'd0);
      chk("rst_mid_ready", {63'b0, bus.s2p_ready_in}, 64'd1);
      mcnt = 0;
      @(negedge clk) rst = 1'b1;
      step();
      h0 = hs_cyc.size();
      for (int i = 1; i <= 5; i++) send_beat(DW'(i));
      chk("rst_mid_vector", out_vec(), seq_vec(1));
      bus.s2p_valid_in = 1'b0;
      step();
      step();
      chk("rst_mid_count", 64'(hs_cyc.size() - h0), 64'd1);
      chk("final_drain", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/s2p.md
# s2p

Serial-to-parallel converter: the receiving counterpart of `p2s`. It collects NUM_ELEMENTS sequential beats from a valid/ready stream into a vector and presents the vector on a parallel valid/ready output. Typical use is after a `conv1d` output stream, gathering a window of results for the next layer.

It is double buffered: a fill buffer and an output register. A new vector can be assembled while the previous one waits for the downstream side.

## Interface

Parameters:
- DATA_WIDTH, 12, width of each element.
- NUM_ELEMENTS, 5, elements per vector; minimum 2.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; asynchronous, active-low.
- s2p_ready_in  output  1  block can accept a serial beat.
- s2p_valid_in  input  1  serial beat valid.
- s2p_serial_in  input  DATA_WIDTH  serial beat data.
- s2p_ready_out  input  1  downstream accepts the vector.
- s2p_valid_out  output  1  s2p_parallel_out holds a complete vector.
- s2p_parallel_out  output  DATA_WIDTH x [0:NUM_ELEMENTS-1]  assembled vector, unpacked array.

## Operation

Internal state:
- fill_buf[0:NUM_ELEMENTS-1]: the fill buffer.
- cnt: clog2(NUM_ELEMENTS) bits, range 0..NUM_ELEMENTS-1.
- full: 1-bit flag.
- States: FILL (full=0) and HELD (full=1).

Control rules:
- s2p_ready_in = ~full, combinational from the register only. It never depends on s2p_valid_in.
- out_free = ~s2p_valid_out | s2p_ready_out.
- Beat accept = s2p_ready_in & s2p_valid_in.

On beat accept:
- Write the beat to fill_buf[cnt]. The first beat maps to element 0; the last beat maps to element NUM_ELEMENTS-1.
- If cnt < NUM_ELEMENTS-1: increment cnt.
- If cnt == NUM_ELEMENTS-1, the vector is complete:
  - cnt wraps to 0.
  - If out_free: load s2p_parallel_out from fill_buf, with element NUM_ELEMENTS-1 taken directly from s2p_serial_in. Set s2p_valid_out to 1.
  - Otherwise: set full to 1 (go to HELD).

In HELD:
- No beats are accepted.
- When out_free: load s2p_parallel_out from fill_buf, set s2p_valid_out to 1, clear full (go to FILL).

Output register:
- If s2p_valid_out & s2p_ready_out and no load occurs in the same cycle, clear s2p_valid_out.
- s2p_parallel_out changes only on a load. It is held while s2p_valid_out=1 and s2p_ready_out=0.
- After the vector is consumed, s2p_parallel_out keeps its last value.

Other rules:
- No arithmetic is performed; data passes bit-exact.
- A partial vector stays in fill_buf indefinitely. There is no timeout and no flush.

## Timing

Reset (rst=0, asynchronous):
- s2p_valid_out=0 and every s2p_parallel_out element=0.
- cnt=0, full=0, fill_buf cleared, so s2p_ready_in=1.
- Reset mid-vector discards the partial vector and any held vector.
- The first beat after reset release is element 0.

Latency and throughput:
- The last beat is accepted at edge k; s2p_valid_out=1 in the cycle after edge k, with the complete vector.
- With downstream always ready: one vector per NUM_ELEMENTS cycles and zero bubbles. s2p_ready_in stays high continuously.

Boundary conditions:
- Downstream stalled:
  - The first completed vector sits in the output register.
  - The second vector fills the fill buffer, then full=1 and s2p_ready_in=0.
  - In the cycle s2p_ready_out rises, the held vector loads at that edge. s2p_ready_in returns to 1 in the next cycle.
  - Total buffering: 2 vectors.
- Simultaneous events: an output handshake and a load at the same edge give s2p_valid_out=1 with the new vector and no bubble.
- Gaps: s2p_valid_in deasserted mid-vector leaves cnt unchanged, so gaps are tolerated anywhere.
- Upstream rule: data must be held until accepted (valid/ready rule); the block does not check it.

## Test plan

Use DATA_WIDTH=12, NUM_ELEMENTS=5.

- **Reset values:** assert rst mid-operation. Check, while rst=0: s2p_valid_out=0, all outputs 0, s2p_ready_in=1.
- **Single vector:** send beats 1,2,3,4,5 back-to-back with s2p_ready_out=1. Check s2p_valid_out=1 for exactly one cycle, the cycle after beat 5, with output [1,2,3,4,5].
- **Streaming:** send 20 consecutive beats 0..19 with s2p_ready_out=1. Check 4 vectors [0..4], [5..9], [10..14], [15..19], spaced exactly 5 cycles apart, with s2p_ready_in never low.
- **Backpressure:** hold s2p_ready_out=0 and send 10 beats 0..9. Check:
  - Output holds [0..4].
  - s2p_ready_in falls in the cycle after beat 9.
  - Raising s2p_ready_out gives [5..9] in the next cycle, then s2p_ready_in=1.
- **Gapped input:** use random s2p_valid_in gaps of 0-3 cycles over 15 beats. Check the vectors are correct and in order.
- **Reset mid-vector:** send 3 beats (7,8,9), pulse rst=0, then send 5 beats (1..5). Check a single output [1,2,3,4,5] with no trace of 7,8,9.
